// File: rtl/fim_cross_event_mux_if.sv
// Event port bundle for fim_cross_event_mux.
//   evt_valid : an event is offered on evt_chan (producer -> consumer)
//   evt_ready : consumer accepts the offered event (consumer -> producer)
//   evt_chan  : index of the channel whose event is offered
// A transfer happens on a clock edge where evt_valid && evt_ready.
interface fim_cross_event_mux_if #(
  parameter int CHANNELS = 4
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic              evt_valid;
  logic              evt_ready;
  logic [CHAN_W-1:0] evt_chan;

  modport master (output evt_valid, output evt_chan, input evt_ready);
  modport slave  (input evt_valid, input evt_chan, output evt_ready);
endinterface

// File: rtl/fim_cross_event_mux.sv
// fim_cross_event_mux: multi-channel event crossing into the clk domain.
// Each asynchronous line is synchronised, edge-detected, and its events are
// accumulated in a saturating counter. Pending events are drained one per
// transfer through a registered round-robin valid/ready port. Events lost
// while a counter is saturated raise a sticky per-channel overflow flag.
// Ports:
//   clk        : destination clock, all logic runs on it
//   rst_n      : asynchronous active-low reset
//   async_in_i : CHANNELS asynchronous event lines
//   ovf_o      : sticky per-channel overflow flags
//   ovf_clr_i  : per-channel single-cycle clear of ovf_o
//   evt_if     : event offer port (valid/ready/chan), master side
module fim_cross_event_mux #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  EDGE_MODE   = 0,
  parameter int                  CNT_WIDTH   = 3,
  parameter logic [CHANNELS-1:0] INIT_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   async_in_i,
  output logic [CHANNELS-1:0]   ovf_o,
  input  logic [CHANNELS-1:0]   ovf_clr_i,
  fim_cross_event_mux_if.master evt_if
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CHAN_W:0] CHANNELS_W = (CHAN_W+1)'(CHANNELS);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

  // Synchroniser: plain flop chain per bit, the last stage is sync_q.
  logic [CHANNELS-1:0] sync_stage_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0] last_q;
  logic [CHANNELS-1:0] det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_stage_q[s] <= INIT_VALUE;
      last_q <= INIT_VALUE;
    end else begin
      sync_stage_q[0] <= async_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_stage_q[s] <= sync_stage_q[s-1];
      last_q <= sync_q;
    end
  end

  assign sync_q = sync_stage_q[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_MODE)
      1:       det = sync_q & ~last_q;
      2:       det = ~sync_q & last_q;
      default: det = sync_q ^ last_q;
    endcase
  end

  // Per-channel pending-event counters.
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] ovf_set;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // A grant in the same cycle as a detect frees the slot the new event
    // takes, so the count holds and no event is lost.
    always_comb begin
      cnt_d = cnt_q;
      if (det[gi] && !grant[gi]) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (grant[gi] && !det[gi]) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign pending[gi] = |cnt_q;
    assign ovf_set[gi] = det[gi] & ~grant[gi] & (cnt_q == CNT_MAX);
  end

  // Sticky overflow: a set in the same cycle as a clear wins.
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;

  assign ovf_d = (ovf_q & ~ovf_clr_i) | ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;

  // Round-robin search from ptr upward, wrapping at CHANNELS.
  logic [CHAN_W-1:0] ptr_q, ptr_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CHAN_W-1:0] evt_chan_q, evt_chan_d;
  logic              found;
  logic [CHAN_W-1:0] win;
  logic [CHAN_W:0]   idx;
  logic              load;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = {1'b0, ptr_q} + (CHAN_W+1)'(i);
      if (idx >= CHANNELS_W) idx = idx - CHANNELS_W;
      if (!found && pending[idx[CHAN_W-1:0]]) begin
        found = 1'b1;
        win   = idx[CHAN_W-1:0];
      end
    end
  end

  // The output register only reloads when empty or being consumed, so an
  // offer stays stable under back-pressure.
  assign load = !evt_valid_q || evt_if.evt_ready;

  always_comb begin
    grant       = '0;
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (found) begin
        grant[win]  = 1'b1;
        evt_valid_d = 1'b1;
        evt_chan_d  = win;
        ptr_d       = (win == LAST_CHAN) ? '0 : win + 1'b1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign evt_if.evt_valid = evt_valid_q;
  assign evt_if.evt_chan  = evt_chan_q;
endmodule

// File: tb/tb_fim_cross_event_mux.sv
// Bench for fim_cross_event_mux: three instances (any-edge, rising-only,
// falling-only) share clock and reset. Every counted event is pushed to the
// instance's queue when driven; every transfer pops and compares the channel.
module tb_fim_cross_event_mux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a0 = '0, a1 = '0, a2 = '0;
  logic [3:0] clr0 = '0, clr1 = '0, clr2 = '0;
  logic [3:0] ovf0, ovf1, ovf2;

  int total = 0;
  int bad = 0;
  int xf0 = 0, xf1 = 0, xf2 = 0;
  int q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  fim_cross_event_mux_if #(.CHANNELS(4)) if0 ();
  fim_cross_event_mux_if #(.CHANNELS(4)) if1 ();
  fim_cross_event_mux_if #(.CHANNELS(4)) if2 ();

  fim_cross_event_mux #(.EDGE_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .async_in_i(a0), .ovf_o(ovf0), .ovf_clr_i(clr0), .evt_if(if0.master));
  fim_cross_event_mux #(.EDGE_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .async_in_i(a1), .ovf_o(ovf1), .ovf_clr_i(clr1), .evt_if(if1.master));
  fim_cross_event_mux #(.EDGE_MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .async_in_i(a2), .ovf_o(ovf2), .ovf_clr_i(clr2), .evt_if(if2.master));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int d, input logic [31:0] chan);
    int exp;
    exp = -1;
    case (d)
      0: begin if (q0.size() > 0) exp = q0.pop_front(); xf0++; end
      1: begin if (q1.size() > 0) exp = q1.pop_front(); xf1++; end
      default: begin if (q2.size() > 0) exp = q2.pop_front(); xf2++; end
    endcase
    $display("xfer u%0d chan=%0d expected=%0d t=%0t", d, chan, exp, $time);
    check($sformatf("xfer_u%0d", d), chan, exp);
  endtask

  // Advance one clock; transfers are judged from values sampled before the edge.
  task automatic step();
    logic x0, x1, x2;
    logic [31:0] c0, c1, c2;
    x0 = if0.evt_valid && if0.evt_ready; c0 = 32'(if0.evt_chan);
    x1 = if1.evt_valid && if1.evt_ready; c1 = 32'(if1.evt_chan);
    x2 = if2.evt_valid && if2.evt_ready; c2 = 32'(if2.evt_chan);
    @(posedge clk);
    #1;
    if (x0) pop_check(0, c0);
    if (x1) pop_check(1, c1);
    if (x2) pop_check(2, c2);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int base;
    if0.evt_ready = 1'b0;
    if1.evt_ready = 1'b1;
    if2.evt_ready = 1'b1;

    // Reset with inputs at INIT_VALUE, then idle 20 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(if0.evt_valid), 0);
    check("rst_chan", 32'(if0.evt_chan), 0);
    check("rst_ovf", 32'(ovf0), 0);
    rst_n = 1'b1;
    if0.evt_ready = 1'b1;
    steps(20);
    check("idle_valid0", 32'(if0.evt_valid), 0);
    check("idle_valid1", 32'(if1.evt_valid), 0);
    check("idle_valid2", 32'(if2.evt_valid), 0);
    check("idle_ovf", 32'(ovf0), 0);

    // Round robin under back-pressure: ch0, ch1, ch3 together.
    if0.evt_ready = 1'b0;
    a0 = a0 ^ 4'b1011;
    q0.push_back(0); q0.push_back(1); q0.push_back(3);
    steps(4);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(if0.evt_valid), 1);
      check("bp_chan", 32'(if0.evt_chan), 0);
      step();
    end
    if0.evt_ready = 1'b1;
    step();
    check("rr_b2b1", 32'(if0.evt_valid), 1);
    step();
    check("rr_b2b2", 32'(if0.evt_valid), 1);
    step();
    check("rr_done", 32'(if0.evt_valid), 0);
    check("rr_queue", 32'(q0.size()), 0);

    // Latency: toggle ch2, valid exactly after edge 4.
    a0[2] = ~a0[2];
    q0.push_back(2);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("lat_e%0d", i), 32'(if0.evt_valid), 0);
    end
    step();
    check("lat_e4_valid", 32'(if0.evt_valid), 1);
    check("lat_e4_chan", 32'(if0.evt_chan), 2);
    step();
    check("lat_after", 32'(if0.evt_valid), 0);

    // Saturation on ch1: 9 edges, 8 counted, the 9th overflows.
    if0.evt_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) check("sat_ovf_pre", 32'(ovf0[1]), 0);
      a0[1] = ~a0[1];
      if (k < 8) q0.push_back(1);
      steps(4);
    end
    check("sat_ovf", 32'(ovf0), 32'h2);
    check("sat_chan", 32'(if0.evt_chan), 1);
    base = xf0;
    if0.evt_ready = 1'b1;
    steps(8);
    check("sat_count", 32'(xf0 - base), 8);
    check("sat_valid", 32'(if0.evt_valid), 0);
    check("sat_sticky", 32'(ovf0[1]), 1);
    clr0 = 4'b0010;
    step();
    clr0 = '0;
    check("sat_clr", 32'(ovf0), 0);

    // Overflow set vs clear on ch0.
    if0.evt_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      a0[0] = ~a0[0];
      if (k < 8) q0.push_back(0);
      steps(4);
    end
    check("ovf0_set", 32'(ovf0), 32'h1);
    a0[0] = ~a0[0];
    steps(2);
    clr0 = 4'b0001;     // clear lands on the same edge as the overflow set
    step();
    clr0 = '0;
    check("ovf_setwins", 32'(ovf0), 32'h1);
    step();
    check("ovf_hold", 32'(ovf0), 32'h1);
    clr0 = 4'b0001;
    step();
    clr0 = '0;
    check("ovf_clr", 32'(ovf0), 0);
    base = xf0;
    if0.evt_ready = 1'b1;
    steps(10);
    check("ovf_drain", 32'(xf0 - base), 8);

    // Rising-only: 0->1->0 yields one event.
    a1[0] = 1'b1;
    q1.push_back(0);
    steps(4);
    check("m1_valid", 32'(if1.evt_valid), 1);
    check("m1_chan", 32'(if1.evt_chan), 0);
    steps(4);
    a1[0] = 1'b0;
    steps(8);
    check("m1_count", 32'(xf1), 1);

    // Falling-only: event presented one level-period later.
    a2[0] = 1'b1;
    steps(4);
    check("m2_rise", 32'(if2.evt_valid), 0);
    steps(4);
    a2[0] = 1'b0;
    q2.push_back(0);
    steps(3);
    check("m2_e3", 32'(if2.evt_valid), 0);
    step();
    check("m2_e4", 32'(if2.evt_valid), 1);
    steps(4);
    check("m2_count", 32'(xf2), 1);

    // Reset mid-operation with three events pending.
    if0.evt_ready = 1'b0;
    a0 = a0 ^ 4'b0111;
    steps(6);
    check("mid_pending", 32'(if0.evt_valid), 1);
    rst_n = 1'b0;
    a0 = '0;
    #1;
    check("mid_rst_valid", 32'(if0.evt_valid), 0);
    steps(3);
    rst_n = 1'b1;
    if0.evt_ready = 1'b1;
    base = xf0;
    steps(20);
    check("mid_after", 32'(xf0 - base), 0);
    check("mid_valid", 32'(if0.evt_valid), 0);
    check("final_q0", 32'(q0.size()), 0);
    check("final_q1", 32'(q1.size()), 0);
    check("final_q2", 32'(q2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fim_cross_event_mux.md
Name: fim_cross_event_mux

Overview:
- Multi-channel successor to the single-pulse strobe crossing, implemented in the receiving clock domain.
- Takes CHANNELS asynchronous toggle/level lines, synchronises each one and detects events on it using a selectable edge mode.
- Keeps a saturating per-channel count of pending events and drains them one event per transaction through a registered, round-robin valid/ready port.
- Reports lost events per channel through sticky overflow flags.

Parameters:
- CHANNELS, 4: number of independent input lines (1..32).
- SYNC_STAGES, 2: synchroniser depth per channel (>=2).
- EDGE_MODE, 0: 0 = any edge (toggle protocol), 1 = rising edge only, 2 = falling edge only.
- CNT_WIDTH, 3: width of each pending-event counter; saturates at 2^CNT_WIDTH-1.
- INIT_VALUE, 0: reset value of the synchroniser and last-value registers.

Ports:
- clk  input  1  destination-domain clock; all logic runs on it.
- rst_n  input  1  asynchronous, active-low reset.
- async_in  input  CHANNELS  asynchronous event lines, one bit per channel, sourced from foreign domains.
- evt_valid  output  1  an event is presented on evt_chan.
- evt_ready  input  1  consumer accepts the event; a transfer occurs when evt_valid && evt_ready.
- evt_chan  output  max(1,$clog2(CHANNELS))  index of the channel whose event is presented.
- ovf  output  CHANNELS  sticky per-channel flag: an event was lost while that channel's counter was saturated.
- ovf_clr  input  CHANNELS  single-cycle clear, one bit per ovf bit.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - evt_valid=0, evt_chan=0, ovf=0.
  - All counters 0, round-robin pointer 0.
  - Synchroniser and last-value registers = INIT_VALUE.
  - An input held at INIT_VALUE through reset produces no spurious event.
- Synchroniser: SYNC_STAGES flops per bit, no logic between stages. Its output is sync_q.
- Detect: compare sync_q against last_q (last_q is sync_q delayed one cycle).
  - Mode 0: det = sync_q ^ last_q.
  - Mode 1: det = sync_q & ~last_q.
  - Mode 2: det = ~sync_q & last_q.
- Counter cnt[c], updated each cycle from det[c] and grant[c]:
  - det only: +1 if cnt < max; if cnt = max, the count is unchanged and ovf[c] is set.
  - grant only: -1.
  - det and grant together: unchanged. No overflow, because the grant frees a slot.
  - A counter never wraps.
- Output register (evt_valid, evt_chan):
  - Loads when evt_valid=0 or a transfer occurs this cycle.
  - The winner is the first channel c, searching from ptr upward modulo CHANNELS, whose cnt[c] > 0.
  - On load with a winner: grant[c]=1, evt_valid=1, evt_chan=c, ptr=(c+1) mod CHANNELS.
  - On load with no winner: evt_valid=0; ptr and evt_chan are unchanged.
  - While evt_valid=1 and evt_ready=0, evt_valid and evt_chan hold stable. The winner is never re-evaluated mid-offer.
- Latency: an input change setup before edge 1 gives sync_q after edge SYNC_STAGES and cnt=1 after edge SYNC_STAGES+1. evt_valid=1 after edge SYNC_STAGES+2, i.e. 4 cycles for the default.
- Throughput: one event per clock with evt_ready held high (back-to-back transfers, no bubble).
- Overflow flags:
  - ovf[c] set and ovf_clr[c] in the same cycle: set wins, ovf[c] stays 1.
  - ovf_clr has no effect on counters.
- Counting capacity: an event counts once it is granted or sits in cnt. The maximum outstanding per channel is 2^CNT_WIDTH-1 in cnt plus 1 in the output register.
- Multiple channels detecting in the same cycle each increment independently.
- Reset asserted mid-operation discards everything at once: pending counts, the presented event and ovf. Nothing is presented after release until new edges arrive.
- Input pulse width is the source's responsibility: each level must be held for at least SYNC_STAGES+1 clk cycles. Shorter pulses may be missed; this is not detected.

Test Plan:
- Reset check: rst_n=0 with async_in=0, then release, no toggles for 20 cycles -> evt_valid stays 0 and ovf=0.
- Latency: defaults; toggle ch2 once -> evt_valid=1 with evt_chan=2 exactly after edge 4; evt_ready=1 -> evt_valid=0 the next cycle.
- Round-robin and back-pressure:
  - Toggle ch0, ch1 and ch3 in the same cycle with evt_ready=0 for 5 cycles -> evt_chan stays 0 throughout.
  - Then evt_ready=1 -> transfers occur in the order 0, 1, 3 on consecutive cycles.
- Saturation and overflow (CNT_WIDTH=3, evt_ready=0):
  - Give ch1 9 edges spaced 4 cycles apart -> 1 event latched in the output register plus cnt=7; ovf[1]=1 after the 9th edge.
  - Drain -> exactly 8 transfers on ch1.
- Overflow set vs clear: with ch0 saturated, ovf_clr[0] pulsed in the same cycle as a new det -> ovf[0] stays 1. A later ovf_clr[0] pulse alone -> ovf[0]=0.
- Edge modes:
  - EDGE_MODE=1, drive 0→1→0 on ch0 -> exactly 1 transfer.
  - EDGE_MODE=2, same stimulus -> 1 transfer, presented 1 level-period later.
  - Reset pulsed while 3 events are pending -> 0 transfers after release.
